// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified-memory arbiter
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Command as latched at grant; also used by the IF/MEM-side stall glue
    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter between instruction fetch and data port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err
);

    localparam int            SW         = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          grant_d, grant_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        i_done   = 1'b0;
        d_done   = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;

        // Data wins unless a waiting fetch has already seen STREAK_MAX data grants
        grant_d = d_req && ((streak_q < STREAK_LIM) || !i_req);
        grant_i = !grant_d && i_req;

        unique case (state_q)
            IDLE: begin
                if (mem_ack) begin
                    err_d = 1'b1;
                end
                if (grant_d) begin
                    state_d = BUSY_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    if (i_req) begin
                        streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    we_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    i_done  = 1'b1;
                    i_rdata = mem_rdata;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    d_done  = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule
